// File: rtl/serializer_link_ctrl_if.sv
// Requester handshake bundle for serializer_link_ctrl: one control and one data
// requester, each with a 10-bit word, a valid and a ready.
interface serializer_link_ctrl_if;
    logic [9:0] ctrl_i;
    logic       ctrl_valid_i;
    logic       ctrl_ready_o;
    logic [9:0] data_i;
    logic       data_valid_i;
    logic       data_ready_o;

    // Requester side drives words and valids, link controller returns readies.
    modport master (
        output ctrl_i, ctrl_valid_i, data_i, data_valid_i,
        input  ctrl_ready_o, data_ready_o
    );

    modport slave (
        input  ctrl_i, ctrl_valid_i, data_i, data_valid_i,
        output ctrl_ready_o, data_ready_o
    );
endinterface

// File: rtl/serializer_link_ctrl.sv
// Word scheduler / link sequencer for a 10:1 DDR serializer. Holds the serializer
// in reset, trains with a fixed pattern, then fills one word slot per cycle from
// sync, control, data or idle, in that priority.
module serializer_link_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned TRAIN_WORDS   = 64,
    parameter logic [9:0]  TRAIN_PATTERN = 10'b1111100000,
    parameter logic [9:0]  IDLE_WORD     = 10'b1101010100,
    parameter logic [9:0]  SYNC_WORD     = 10'b0010101011,
    parameter int unsigned SYNC_PERIOD   = 1024
) (
    input  logic                   ref_clk_i,
    input  logic                   rst_n,
    input  logic                   retrain_i,
    serializer_link_ctrl_if.slave  req,
    output logic                   ser_rst_o,
    output logic [9:0]             ser_dat_o,
    output logic                   link_up_o,
    output logic [1:0]             state_o
);

    localparam int unsigned RstW   = (RST_CYCLES > 1)  ? $clog2(RST_CYCLES)  : 1;
    localparam int unsigned TrainW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    // One phase counter is shared by RESET and TRAIN, so size it for the larger.
    localparam int unsigned PhW    = (RstW > TrainW) ? RstW : TrainW;
    localparam int unsigned SlotW  = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

    localparam logic [PhW-1:0]   RstLast   = PhW'(RST_CYCLES - 1);
    localparam logic [PhW-1:0]   TrainLast = PhW'(TRAIN_WORDS - 1);
    localparam logic [SlotW-1:0] SlotLast  =
        SlotW'((SYNC_PERIOD == 32'd0) ? 32'd0 : SYNC_PERIOD - 1);

    typedef enum logic [1:0] {
        StReset = 2'b00,
        StTrain = 2'b01,
        StRun   = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic             ser_rst_q, ser_rst_d;
    logic [9:0]       ser_dat_q, ser_dat_d;
    logic             link_up_q, link_up_d;
    logic             run;
    logic             sync_due;

    assign run      = (state_q == StRun);
    assign sync_due = (SYNC_PERIOD != 32'd0) && run && (slot_q == SlotLast);

    // Grants are combinational so a requester sees acceptance in the same cycle.
    assign req.ctrl_ready_o = run & ~sync_due & ~retrain_i;
    assign req.data_ready_o = run & ~sync_due & ~retrain_i & ~req.ctrl_valid_i;

    assign ser_rst_o = ser_rst_q;
    assign ser_dat_o = ser_dat_q;
    assign link_up_o = link_up_q;
    assign state_o   = state_q;

    // Next-state logic; registered outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        slot_d    = slot_q;
        ser_rst_d = ser_rst_q;
        ser_dat_d = ser_dat_q;
        link_up_d = link_up_q;
        unique case (state_q)
            StReset: begin
                ser_rst_d = 1'b1;
                ser_dat_d = '0;
                link_up_d = 1'b0;
                if (phase_q == RstLast) begin
                    state_d   = StTrain;
                    phase_d   = '0;
                    ser_rst_d = 1'b0;
                    ser_dat_d = TRAIN_PATTERN;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StTrain: begin
                ser_dat_d = TRAIN_PATTERN;
                link_up_d = 1'b0;
                if (retrain_i) begin
                    phase_d = '0;
                end else if (phase_q == TrainLast) begin
                    state_d   = StRun;
                    phase_d   = '0;
                    slot_d    = '0;
                    link_up_d = 1'b1;
                    ser_dat_d = IDLE_WORD;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StRun: begin
                if (retrain_i) begin
                    state_d   = StTrain;
                    phase_d   = '0;
                    link_up_d = 1'b0;
                    ser_dat_d = TRAIN_PATTERN;
                end else begin
                    slot_d = sync_due ? '0 : slot_q + SlotW'(1);
                    if (sync_due) begin
                        ser_dat_d = SYNC_WORD;
                    end else if (req.ctrl_valid_i) begin
                        ser_dat_d = req.ctrl_i;
                    end else if (req.data_valid_i) begin
                        ser_dat_d = req.data_i;
                    end else begin
                        ser_dat_d = IDLE_WORD;
                    end
                end
            end
            default: begin
                state_d   = StReset;
                phase_d   = '0;
                slot_d    = '0;
                ser_rst_d = 1'b1;
                ser_dat_d = '0;
                link_up_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts straight back to serializer reset.
    always_ff @(posedge ref_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StReset;
            phase_q   <= '0;
            slot_q    <= '0;
            ser_rst_q <= 1'b1;
            ser_dat_q <= '0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            ser_rst_q <= ser_rst_d;
            ser_dat_q <= ser_dat_d;
            link_up_q <= link_up_d;
        end
    end

endmodule

// File: tb/tb_serializer_link_ctrl.sv
// Directed bench for serializer_link_ctrl: a default build plus a SYNC_PERIOD=0 build.
module tb_serializer_link_ctrl;

    localparam logic [9:0] PAT  = 10'b1111100000;
    localparam logic [9:0] IDLE = 10'b1101010100;
    localparam logic [9:0] SYNC = 10'b0010101011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_retrain = 1'b0;
    logic       b_retrain = 1'b0;
    logic       a_ser_rst, b_ser_rst;
    logic [9:0] a_dat, b_dat;
    logic       a_link, b_link;
    logic [1:0] a_state, b_state;

    int checks = 0;
    int failures = 0;
    int slot = 0;
    int syncs = 0;

    serializer_link_ctrl_if a_if ();
    serializer_link_ctrl_if b_if ();

    always #5 clk = ~clk;

    serializer_link_ctrl dut_a (
        .ref_clk_i (clk),
        .rst_n     (rst_n),
        .retrain_i (a_retrain),
        .req       (a_if),
        .ser_rst_o (a_ser_rst),
        .ser_dat_o (a_dat),
        .link_up_o (a_link),
        .state_o   (a_state)
    );

    serializer_link_ctrl #(.SYNC_PERIOD(0)) dut_b (
        .ref_clk_i (clk),
        .rst_n     (rst_n),
        .retrain_i (b_retrain),
        .req       (b_if),
        .ser_rst_o (b_ser_rst),
        .ser_dat_o (b_dat),
        .link_up_o (b_link),
        .state_o   (b_state)
    );

    typedef struct {
        logic       retrain;
        logic       cv;
        logic [9:0] c;
        logic       dv;
        logic [9:0] d;
        logic       exp_cr;
        logic       exp_dr;
        logic [9:0] exp_dat;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expects rst_n just released after an edge; ends right after the RUN entry edge.
    task automatic bring_up();
        a_if.ctrl_valid_i = 1'b1;
        a_if.data_valid_i = 1'b1;
        settle();
        chk("rst_crdy", 16'(a_if.ctrl_ready_o), 16'd0);
        chk("rst_drdy", 16'(a_if.data_ready_o), 16'd0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("rst_serrst", 16'(a_ser_rst), 16'd1);
            chk("rst_state", 16'(a_state), 16'd0);
        end
        tick();
        chk("train_state", 16'(a_state), 16'd1);
        chk("train_serrst", 16'(a_ser_rst), 16'd0);
        chk("train_dat", 16'(a_dat), 16'(PAT));
        chk("train_link", 16'(a_link), 16'd0);
        settle();
        chk("train_crdy", 16'(a_if.ctrl_ready_o), 16'd0);
        chk("train_drdy", 16'(a_if.data_ready_o), 16'd0);
        for (int i = 1; i <= 63; i++) begin
            tick();
            chk("train_state", 16'(a_state), 16'd1);
            chk("train_dat", 16'(a_dat), 16'(PAT));
        end
        a_if.ctrl_valid_i = 1'b0;
        a_if.data_valid_i = 1'b0;
        tick();
        chk("run_state", 16'(a_state), 16'd2);
        chk("run_link", 16'(a_link), 16'd1);
        chk("run_dat", 16'(a_dat), 16'(IDLE));
        chk("run_serrst", 16'(a_ser_rst), 16'd0);
        chk("b_run_state", 16'(b_state), 16'd2);
        slot = 0;
    endtask

    initial begin
        int w;
        logic is_sync;

        // retrain, cv, c, dv, d, exp ctrl_ready, exp data_ready, exp next dat, exp next state
        vecs[0] = '{1'b0, 1'b1, 10'h0A1, 1'b1, 10'h1B2, 1'b1, 1'b0, 10'h0A1, 2'd2};
        vecs[1] = '{1'b0, 1'b1, 10'h0A2, 1'b1, 10'h1B2, 1'b1, 1'b0, 10'h0A2, 2'd2};
        vecs[2] = '{1'b0, 1'b1, 10'h0A3, 1'b1, 10'h1B2, 1'b1, 1'b0, 10'h0A3, 2'd2};
        vecs[3] = '{1'b0, 1'b0, 10'h0A3, 1'b1, 10'h1B2, 1'b1, 1'b1, 10'h1B2, 2'd2};
        vecs[4] = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, IDLE,    2'd2};
        vecs[5] = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h2C3, 1'b1, 1'b1, 10'h2C3, 2'd2};
        vecs[6] = '{1'b1, 1'b1, 10'h0A4, 1'b1, 10'h155, 1'b0, 1'b0, PAT,     2'd1};

        a_if.ctrl_i = '0;
        a_if.ctrl_valid_i = 1'b0;
        a_if.data_i = '0;
        a_if.data_valid_i = 1'b0;
        b_if.ctrl_i = '0;
        b_if.ctrl_valid_i = 1'b0;
        b_if.data_i = 10'h3F0;
        b_if.data_valid_i = 1'b1;

        // Held in reset
        tick();
        tick();
        chk("por_state", 16'(a_state), 16'd0);
        chk("por_serrst", 16'(a_ser_rst), 16'd1);
        chk("por_dat", 16'(a_dat), 16'd0);
        chk("por_link", 16'(a_link), 16'd0);
        rst_n = 1'b1;
        bring_up();

        // Idle fill
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_dat", 16'(a_dat), 16'(IDLE));
            slot++;
        end

        // Arbitration table, ending in a retrain pulse
        foreach (vecs[i]) begin
            a_retrain = vecs[i].retrain;
            a_if.ctrl_valid_i = vecs[i].cv;
            a_if.ctrl_i = vecs[i].c;
            a_if.data_valid_i = vecs[i].dv;
            a_if.data_i = vecs[i].d;
            settle();
            chk("vec_crdy", 16'(a_if.ctrl_ready_o), 16'(vecs[i].exp_cr));
            chk("vec_drdy", 16'(a_if.data_ready_o), 16'(vecs[i].exp_dr));
            tick();
            chk("vec_dat", 16'(a_dat), 16'(vecs[i].exp_dat));
            chk("vec_state", 16'(a_state), 16'(vecs[i].exp_st));
            slot++;
        end
        a_retrain = 1'b0;
        a_if.ctrl_valid_i = 1'b0;
        chk("retrain_link", 16'(a_link), 16'd0);
        chk("retrain_serrst", 16'(a_ser_rst), 16'd0);

        // Pending data word held through training; retrain inside TRAIN restarts the count
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rt_state", 16'(a_state), 16'd1);
        end
        a_retrain = 1'b1;
        settle();
        chk("rt_drdy", 16'(a_if.data_ready_o), 16'd0);
        tick();
        a_retrain = 1'b0;
        chk("rt2_state", 16'(a_state), 16'd1);
        for (int i = 1; i <= 63; i++) begin
            tick();
            chk("rt2_state", 16'(a_state), 16'd1);
            chk("rt2_dat", 16'(a_dat), 16'(PAT));
            chk("rt2_serrst", 16'(a_ser_rst), 16'd0);
        end
        tick();
        chk("rerun_state", 16'(a_state), 16'd2);
        chk("rerun_link", 16'(a_link), 16'd1);
        chk("rerun_dat", 16'(a_dat), 16'(IDLE));
        settle();
        chk("rerun_drdy", 16'(a_if.data_ready_o), 16'd1);
        tick();
        chk("pending_dat", 16'(a_dat), 16'h155);
        slot = 1;

        // Incrementing data stream across the sync slot
        w = 1;
        while (w <= 1023) begin
            a_if.data_i = 10'(w);
            settle();
            is_sync = (slot == 1023);
            chk("strm_drdy", 16'(a_if.data_ready_o), 16'(!is_sync));
            tick();
            if (is_sync) begin
                chk("strm_sync", 16'(a_dat), 16'(SYNC));
                syncs++;
            end else begin
                chk("strm_dat", 16'(a_dat), 16'(w));
                w++;
            end
            slot = (slot + 1) % 1024;
        end
        a_if.data_valid_i = 1'b0;
        chk("strm_sync_count", 16'(syncs), 16'd1);

        // Asynchronous reset in the middle of training
        a_retrain = 1'b1;
        settle();
        tick();
        a_retrain = 1'b0;
        chk("rt3_state", 16'(a_state), 16'd1);
        for (int i = 0; i < 5; i++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 16'(a_state), 16'd0);
        chk("arst_serrst", 16'(a_ser_rst), 16'd1);
        chk("arst_dat", 16'(a_dat), 16'd0);
        chk("arst_link", 16'(a_link), 16'd0);
        tick();
        rst_n = 1'b1;
        bring_up();

        // Sync cadence on the default build; none at all with SYNC_PERIOD=0
        syncs = 0;
        for (int n = 0; n < 5000; n++) begin
            settle();
            chk("b_drdy", 16'(b_if.data_ready_o), 16'd1);
            is_sync = (slot == 1023);
            tick();
            chk("a_cadence", 16'(a_dat), is_sync ? 16'(SYNC) : 16'(IDLE));
            chk("b_nosync", 16'(b_dat), 16'h3F0);
            if (is_sync) syncs++;
            slot = (slot + 1) % 1024;
        end
        chk("a_sync_count", 16'(syncs), 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
